// File: rtl/issue_ctrl.sv
// Issue/hazard controller: per-register scoreboard, RAW/WAW stall,
// redirect flush sequencing and stall/flush event counters.
module issue_ctrl #(
  parameter int NREG         = 32,
  parameter int RA_W         = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifu_valid,
  output logic             ifu_ready,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_regwr,
  output logic             idu_valid,
  input  logic             exu_ready,
  input  logic             wb_valid,
  input  logic             wb_regwr,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             redirect_valid,
  output logic             flush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam int FC_W =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [1:0]       state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic haz, issue, in_flush;
  logic wb_clr, id_set;

  // Registered busy only: the regfile has no write-to-read bypass.
  assign haz =
    (id_rs1_used & (id_rs1 != '0) & busy_q[id_rs1]) |
    (id_rs2_used & (id_rs2 != '0) & busy_q[id_rs2]) |
    (id_regwr    & (id_rd  != '0) & busy_q[id_rd]);

  assign in_flush = (state_q == FLUSH);

  always_comb begin
    idu_valid = 1'b0;
    ifu_ready = 1'b0;
    flush_o   = 1'b0;
    if (rst) begin
      unique case (1'b1)
        in_flush: begin
          ifu_ready = 1'b1;
          flush_o   = 1'b1;
        end
        !in_flush: begin
          idu_valid = ifu_valid & ~haz & ~redirect_valid;
          ifu_ready = exu_ready & ~haz & ~redirect_valid;
          flush_o   = redirect_valid;
        end
      endcase
    end
  end

  assign issue  = idu_valid & exu_ready;
  assign wb_clr = wb_valid & wb_regwr & (wb_rd != '0);
  assign id_set = issue & id_regwr & (id_rd != '0);

  // Set after clear: the issuing instruction is the younger writer.
  always_comb begin
    busy_d = busy_q;
    if (wb_clr) busy_d[wb_rd] = 1'b0;
    if (id_set) busy_d[id_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    flush_d = flush_q;
    stall_d = stall_q;
    if (state_q == STALL) stall_d = stall_q + C_ONE;
    if (redirect_valid) begin
      state_d = FLUSH;
      fcnt_d  = FC_LOAD;
      flush_d = flush_q + C_ONE;
    end else begin
      unique case (state_q)
        RUN:
          if (ifu_valid & haz) state_d = STALL;
        STALL:
          if (~haz | ~ifu_valid) state_d = RUN;
        FLUSH:
          if (fcnt_q == '0) state_d = RUN;
          else fcnt_d = fcnt_q - FC_ONE;
        default:
          state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      state_q <= RUN;
      fcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      busy_q  <= busy_d;
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign state_o   = state_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: per-cycle vector table plus
// a hand-written reset-during-stall sequence.
module tb_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        ifu_valid;
  logic        ifu_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_regwr;
  logic        idu_valid;
  logic        exu_ready;
  logic        wb_valid, wb_regwr;
  logic [4:0]  wb_rd;
  logic        redirect_valid;
  logic        flush_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt, flush_cnt;

  int n_chk;
  int n_fail;

  issue_ctrl #(
    .NREG(32), .RA_W(5), .FLUSH_CYCLES(2), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_regwr(id_regwr), .idu_valid(idu_valid),
    .exu_ready(exu_ready), .wb_valid(wb_valid),
    .wb_regwr(wb_regwr), .wb_rd(wb_rd),
    .redirect_valid(redirect_valid), .flush_o(flush_o),
    .state_o(state_o), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, rw, er, wv;
    logic [4:0] wrd;
    logic       rdr;
    logic       e_idv, e_ifr, e_fl;
    logic [1:0] e_st;
    int         e_sc, e_fc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic iv, input int rs1, input int rs2, input int rd,
    input logic u1, input logic u2, input logic rw, input logic er,
    input logic wv, input int wrd, input logic rdr,
    input logic e_idv, input logic e_ifr, input logic e_fl,
    input int e_st, input int e_sc, input int e_fc);
    vec_t r;
    r.iv = iv; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
    r.u1 = u1; r.u2 = u2; r.rw = rw; r.er = er;
    r.wv = wv; r.wrd = 5'(wrd); r.rdr = rdr;
    r.e_idv = e_idv; r.e_ifr = e_ifr; r.e_fl = e_fl;
    r.e_st = 2'(e_st); r.e_sc = e_sc; r.e_fc = e_fc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    ifu_valid = t.iv;
    id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
    id_rs1_used = t.u1; id_rs2_used = t.u2; id_regwr = t.rw;
    exu_ready = t.er;
    wb_valid = t.wv; wb_regwr = t.wv; wb_rd = t.wrd;
    redirect_valid = t.rdr;
  endtask

  initial begin
    vec_t z;
    n_chk = 0;
    n_fail = 0;

    // iv rs1 rs2 rd u1 u2 rw er wv wrd rdr | idv ifr fl st sc fc
    // RAW stall on x5, then release by writeback
    tbl.push_back(v(1, 0,0, 5, 0,0,1,1, 0, 0,0, 1,1,0,0,0,0));
    tbl.push_back(v(1, 5,1, 6, 1,1,1,1, 0, 0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1, 5,1, 6, 1,1,1,1, 0, 0,0, 0,0,0,1,0,0));
    tbl.push_back(v(1, 5,1, 6, 1,1,1,1, 1, 5,0, 0,0,0,1,1,0));
    tbl.push_back(v(1, 5,1, 6, 1,1,1,1, 0, 0,0, 1,1,0,1,2,0));
    tbl.push_back(v(0, 0,0, 0, 0,0,0,1, 0, 0,0, 0,1,0,0,3,0));
    // wb to x7 with same-cycle issue rd=7; reader of x7 stalls
    tbl.push_back(v(1, 0,0, 7, 0,0,1,1, 1, 7,0, 1,1,0,0,3,0));
    tbl.push_back(v(1, 7,0, 0, 1,0,0,1, 0, 0,0, 0,0,0,0,3,0));
    tbl.push_back(v(0, 7,0, 0, 1,0,0,1, 1, 7,0, 0,0,0,1,3,0));
    tbl.push_back(v(0, 0,0, 0, 0,0,0,1, 1, 6,0, 0,1,0,0,4,0));
    // x0 destination/source and unused rs2 on a busy register
    tbl.push_back(v(1, 0,0, 0, 0,0,1,1, 0, 0,0, 1,1,0,0,4,0));
    tbl.push_back(v(1, 0,0, 0, 1,0,1,1, 0, 0,0, 1,1,0,0,4,0));
    tbl.push_back(v(1, 0,0, 9, 0,0,1,1, 0, 0,0, 1,1,0,0,4,0));
    tbl.push_back(v(1, 1,9,10, 1,0,1,1, 0, 0,0, 1,1,0,0,4,0));
    tbl.push_back(v(0, 0,0, 0, 0,0,0,1, 1, 9,0, 0,1,0,0,4,0));
    tbl.push_back(v(0, 0,0, 0, 0,0,0,1, 1,10,0, 0,1,0,0,4,0));
    // single redirect: two flush cycles
    tbl.push_back(v(1, 0,0, 0, 0,0,0,1, 0, 0,1, 0,0,1,0,4,0));
    tbl.push_back(v(1, 0,0, 0, 0,0,0,1, 0, 0,0, 0,1,1,2,4,1));
    tbl.push_back(v(1, 0,0, 0, 0,0,0,1, 0, 0,0, 0,1,1,2,4,1));
    tbl.push_back(v(1, 0,0, 0, 0,0,0,1, 0, 0,0, 1,1,0,0,4,1));
    // redirect repeated in first flush cycle extends flush
    tbl.push_back(v(1, 0,0, 0, 0,0,0,1, 0, 0,1, 0,0,1,0,4,1));
    tbl.push_back(v(1, 0,0, 0, 0,0,0,1, 0, 0,1, 0,1,1,2,4,2));
    tbl.push_back(v(1, 0,0, 0, 0,0,0,1, 0, 0,0, 0,1,1,2,4,3));
    tbl.push_back(v(1, 0,0, 0, 0,0,0,1, 0, 0,0, 0,1,1,2,4,3));
    tbl.push_back(v(1, 0,0, 0, 0,0,0,1, 0, 0,0, 1,1,0,0,4,3));
    // EXU backpressure: held valid, no busy set until accepted
    tbl.push_back(v(1, 0,0,11, 0,0,1,0, 0, 0,0, 1,0,0,0,4,3));
    tbl.push_back(v(1, 0,0,11, 0,0,1,0, 0, 0,0, 1,0,0,0,4,3));
    tbl.push_back(v(1, 0,0,11, 0,0,1,0, 0, 0,0, 1,0,0,0,4,3));
    tbl.push_back(v(1, 0,0,11, 0,0,1,1, 0, 0,0, 1,1,0,0,4,3));
    tbl.push_back(v(1,11,0, 0, 1,0,0,1, 0, 0,0, 0,0,0,0,4,3));
    tbl.push_back(v(0,11,0, 0, 1,0,0,1, 1,11,0, 0,0,0,1,4,3));
    tbl.push_back(v(0, 0,0, 0, 0,0,0,1, 0, 0,0, 0,1,0,0,5,3));

    // reset with inputs that would otherwise issue
    z = v(1, 0,0, 0, 0,0,0,1, 0, 0,0, 0,0,0,0,0,0);
    rst = 1'b0;
    drive(z);
    #1;
    chk("rst idu_valid", 64'(idu_valid), 64'd0);
    chk("rst ifu_ready", 64'(ifu_ready), 64'd0);
    chk("rst flush_o", 64'(flush_o), 64'd0);
    chk("rst state_o", 64'(state_o), 64'd0);
    chk("rst stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst flush_cnt", 64'(flush_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d idu_valid", i),
          64'(idu_valid), 64'(tbl[i].e_idv));
      chk($sformatf("v%0d ifu_ready", i),
          64'(ifu_ready), 64'(tbl[i].e_ifr));
      chk($sformatf("v%0d flush_o", i),
          64'(flush_o), 64'(tbl[i].e_fl));
      chk($sformatf("v%0d state_o", i),
          64'(state_o), 64'(tbl[i].e_st));
      chk($sformatf("v%0d stall_cnt", i),
          64'(stall_cnt), 64'(tbl[i].e_sc));
      chk($sformatf("v%0d flush_cnt", i),
          64'(flush_cnt), 64'(tbl[i].e_fc));
    end
    @(negedge clk);
    chk("busy drained", 64'(dut.busy_q), 64'd0);

    // reset asserted mid-stall with x5 busy
    drive(v(1, 0,0, 5, 0,0,1,1, 0, 0,0, 0,0,0,0,0,0));
    @(negedge clk);
    drive(v(1, 5,0, 0, 1,0,0,1, 0, 0,0, 0,0,0,0,0,0));
    @(negedge clk);
    #1;
    chk("pre-rst state_o", 64'(state_o), 64'd1);
    chk("pre-rst busy5", 64'(dut.busy_q[5]), 64'd1);
    @(negedge clk);
    chk("pre-rst stall_cnt", 64'(stall_cnt), 64'd6);
    rst = 1'b0;
    #1;
    chk("mid-rst idu_valid", 64'(idu_valid), 64'd0);
    chk("mid-rst ifu_ready", 64'(ifu_ready), 64'd0);
    chk("mid-rst state_o", 64'(state_o), 64'd0);
    chk("mid-rst stall_cnt", 64'(stall_cnt), 64'd0);
    chk("mid-rst flush_cnt", 64'(flush_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post-rst busy", 64'(dut.busy_q), 64'd0);
    chk("post-rst idu_valid", 64'(idu_valid), 64'd1);
    chk("post-rst ifu_ready", 64'(ifu_ready), 64'd1);
    chk("post-rst state_o", 64'(state_o), 64'd0);
    chk("post-rst stall_cnt", 64'(stall_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Issue/hazard controller between the IFU→IDU stage and the EXU.
- Keeps a per-register scoreboard of in-flight writes and stalls IDU issue on RAW/WAW hazards.
- Sequences pipeline flushes on EXU redirects (taken branch, jump, interrupt).
- Drives the IFU/IDU/EXU valid-ready handshake and counts stall cycles.

Parameters:
- NREG, 32, number of architectural integer registers (x0 is hard-wired zero).
- RA_W, 5, register-index width.
- FLUSH_CYCLES, 2, cycles issue is blocked after a redirect (≥1).
- CNT_W, 32, stall/flush counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ifu_valid  in  1  IDU holds a decoded instruction.
- ifu_ready  out  1  IDU may accept/advance the next instruction.
- id_rs1  in  RA_W  source register 1 index.
- id_rs2  in  RA_W  source register 2 index.
- id_rd  in  RA_W  destination register index.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_regwr  in  1  instruction writes rd.
- idu_valid  out  1  instruction issued to EXU this cycle.
- exu_ready  in  1  EXU accepts an instruction.
- wb_valid  in  1  writeback occurring this cycle.
- wb_regwr  in  1  writeback writes a register.
- wb_rd  in  RA_W  writeback destination.
- redirect_valid  in  1  EXU redirect; younger instructions are invalid.
- flush_o  out  1  kill IFU/IDU pipeline registers.
- state_o  out  2  current state (RUN=0, STALL=1, FLUSH=2).
- stall_cnt  out  CNT_W  cycles spent in STALL.
- flush_cnt  out  CNT_W  number of redirects accepted.

Behaviour:
- Reset (rst=0, asynchronous): busy[NREG-1:0]=0, state=RUN, flush counter=0, stall_cnt=0, flush_cnt=0. While rst=0, idu_valid=0, ifu_ready=0, flush_o=0.
- Hazard, combinational:
  - haz = (id_rs1_used & id_rs1≠0 & busy[id_rs1]) | (id_rs2_used & id_rs2≠0 & busy[id_rs2]) | (id_regwr & id_rd≠0 & busy[id_rd]).
  - Uses registered busy only. A writeback in the same cycle does not unblock; the regfile has no bypass.
- Outputs, combinational from state and inputs:
  - RUN/STALL: idu_valid = ifu_valid & ~haz & ~redirect_valid. ifu_ready = ~haz & exu_ready & ~redirect_valid.
  - FLUSH: idu_valid=0, ifu_ready=1 (discard), flush_o=1.
  - flush_o is also 1 in any state in the cycle redirect_valid=1.
- issue = idu_valid & exu_ready.
- Scoreboard update each clock edge:
  - Clear busy[wb_rd] if wb_valid & wb_regwr & wb_rd≠0.
  - Set busy[id_rd] if issue & id_regwr & id_rd≠0.
  - Set and clear on the same register in the same cycle: set wins, because the issuing instruction is younger.
  - busy[0] is always 0.
  - WAW stall guarantees at most one in-flight writer per register.
  - Writeback to a non-busy register is ignored.
- State transitions (redirect has highest priority):
  - Any state, redirect_valid=1 → FLUSH; counter loads FLUSH_CYCLES-1; flush_cnt+1.
  - FLUSH: counter decrements each cycle; at 0 → RUN. A redirect during FLUSH reloads the counter and still increments flush_cnt.
  - RUN: ifu_valid & haz → STALL; otherwise stay.
  - STALL: ~haz | ~ifu_valid → RUN; otherwise stay. stall_cnt+1 for every cycle in STALL.
  - exu_ready=0 with no hazard is backpressure, not STALL: stay in RUN, hold idu_valid, do not count.
- Counters wrap modulo 2^CNT_W.
- Redirect does not clear busy bits. Instructions already issued complete writeback, so pending writes drain normally.

Test Plan:
- Reset mid-stall:
  - Stimulus: busy[5]=1, state=STALL, then drop rst.
  - Required response: same cycle idu_valid=0, ifu_ready=0; after release state_o=0, busy all 0, stall_cnt=0.
- RAW stall:
  - Stimulus: issue addi x5 (regwr, rd=5); next cycle present add x6,x5,x1 (rs1=5 used).
  - Required response: idu_valid=0, state_o=1, stall_cnt increments per cycle.
  - Stimulus: wb_valid, wb_rd=5.
  - Required response: next cycle idu_valid=1, state_o=0.
- Same-cycle writeback and reissue:
  - Stimulus: wb clears x7 while a new instruction issues with rd=7.
  - Required response: busy[7]=1 afterwards; a following reader of x7 stalls.
- x0 and unused sources:
  - Stimulus: issue rd=0 repeatedly; then an instruction with id_rs2_used=0 and id_rs2=busy register.
  - Required response: no stall in either case; busy[0] stays 0.
- Redirect:
  - Stimulus: FLUSH_CYCLES=2; redirect_valid for 1 cycle while ifu_valid=1 and no hazard.
  - Required response: that cycle idu_valid=0, flush_o=1; two FLUSH cycles with ifu_ready=1, flush_o=1; then RUN; flush_cnt=1.
  - Stimulus: second redirect in the first FLUSH cycle.
  - Required response: FLUSH extends 2 more cycles; flush_cnt=2.
- Backpressure:
  - Stimulus: exu_ready=0 for 3 cycles, no hazard.
  - Required response: idu_valid=1 held, ifu_ready=0, state_o=0, stall_cnt unchanged, no busy bit set until exu_ready=1.
